axi4_mem_responder: RTL and testbench

//  AXI4 slave memory model answering a kernel's mem0 master port (INCR bursts, full-width beats) from an internal RAM.

---
 rtl/axi4_mem_responder_if.sv | 41 ++++
 rtl/axi4_mem_responder.sv | 125 ++++++++++++
 tb/tb_axi4_mem_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axi4_mem_responder_if.sv
// axi4_mem_responder_if: AXI4 mem0 channel bundle between a kernel master and the memory responder
interface axi4_mem_responder_if #(parameter int ADDR_W = 64, parameter int DATA_W = 512);
  localparam int NB = DATA_W / 8;
  logic              s_AWREADY;
  logic              s_AWVALID;
  logic [ADDR_W-1:0] s_AWADDR;
  logic [7:0]        s_AWLEN;
  logic [5:0]        s_AWID;
  logic              s_WREADY;
  logic              s_WVALID;
  logic [DATA_W-1:0] s_WDATA;
  logic [NB-1:0]     s_WSTRB;
  logic              s_WLAST;
  logic              s_BREADY;
  logic              s_BVALID;
  logic [5:0]        s_BID;
  logic [1:0]        s_BRESP;
  logic              s_ARREADY;
  logic              s_ARVALID;
  logic [ADDR_W-1:0] s_ARADDR;
  logic [7:0]        s_ARLEN;
  logic [5:0]        s_ARID;
  logic              s_RREADY;
  logic              s_RVALID;
  logic [DATA_W-1:0] s_RDATA;
  logic [5:0]        s_RID;
  logic              s_RLAST;
  logic [1:0]        s_RRESP;
  modport slave (
    input  s_AWVALID, s_AWADDR, s_AWLEN, s_AWID, s_WVALID, s_WDATA, s_WSTRB, s_WLAST, s_BREADY,
           s_ARVALID, s_ARADDR, s_ARLEN, s_ARID, s_RREADY,
    output s_AWREADY, s_WREADY, s_BVALID, s_BID, s_BRESP, s_ARREADY, s_RVALID, s_RDATA, s_RID,
           s_RLAST, s_RRESP
  );
  modport master (
    output s_AWVALID, s_AWADDR, s_AWLEN, s_AWID, s_WVALID, s_WDATA, s_WSTRB, s_WLAST, s_BREADY,
           s_ARVALID, s_ARADDR, s_ARLEN, s_ARID, s_RREADY,
    input  s_AWREADY, s_WREADY, s_BVALID, s_BID, s_BRESP, s_ARREADY, s_RVALID, s_RDATA, s_RID,
           s_RLAST, s_RRESP
  );
endinterface

// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 slave RAM model with independent single-outstanding INCR read and write engines
module axi4_mem_responder #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int DEPTH_LOG2 = 10
) (
  input logic clk,
  input logic reset,
  axi4_mem_responder_if.slave s
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  w_state_t w_st;
  r_state_t r_st;
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] w_idx, r_idx;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic [5:0] w_id, r_id;
  logic w_err, w_fire, w_err_nxt;
  assign w_fire = w_st == W_DATA && s.s_WVALID && s.s_WREADY;
  // a burst ends on its beat count; WLAST only grades the master's framing
  assign w_err_nxt = w_err | (s.s_WLAST != (w_cnt == w_len));
  assign s.s_RRESP = 2'b00;
  always_ff @(posedge clk)
    if (w_fire && !reset)
      for (int i = 0; i < NB; i++)
        if (s.s_WSTRB[i]) mem[w_idx][8*i +: 8] <= s.s_WDATA[8*i +: 8];
  always_ff @(posedge clk)
    if (reset) begin
      w_st <= W_IDLE;
      s.s_AWREADY <= 1'b0;
      s.s_WREADY <= 1'b0;
      s.s_BVALID <= 1'b0;
      s.s_BID <= '0;
      s.s_BRESP <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_id <= '0;
      w_err <= 1'b0;
    end else
      case (w_st)
        W_IDLE: begin
          s.s_AWREADY <= 1'b1;
          if (s.s_AWVALID && s.s_AWREADY) begin
            w_idx <= s.s_AWADDR[OFF+DEPTH_LOG2-1:OFF];
            w_len <= s.s_AWLEN;
            w_id <= s.s_AWID;
            w_cnt <= '0;
            w_err <= 1'b0;
            s.s_AWREADY <= 1'b0;
            s.s_WREADY <= 1'b1;
            w_st <= W_DATA;
          end
        end
        W_DATA:
          if (w_fire) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt + 8'd1;
            w_err <= w_err_nxt;
            if (w_cnt == w_len) begin
              s.s_WREADY <= 1'b0;
              s.s_BVALID <= 1'b1;
              s.s_BID <= w_id;
              s.s_BRESP <= w_err_nxt ? 2'b10 : 2'b00;
              w_st <= W_RESP;
            end
          end
        W_RESP:
          if (s.s_BREADY) begin
            s.s_BVALID <= 1'b0;
            s.s_AWREADY <= 1'b1;
            w_st <= W_IDLE;
          end
        default: w_st <= W_IDLE;
      endcase
  always_ff @(posedge clk)
    if (reset) begin
      r_st <= R_IDLE;
      s.s_ARREADY <= 1'b0;
      s.s_RVALID <= 1'b0;
      s.s_RDATA <= '0;
      s.s_RID <= '0;
      s.s_RLAST <= 1'b0;
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_id <= '0;
    end else
      case (r_st)
        R_IDLE: begin
          s.s_ARREADY <= 1'b1;
          if (s.s_ARVALID && s.s_ARREADY) begin
            r_idx <= s.s_ARADDR[OFF+DEPTH_LOG2-1:OFF];
            r_len <= s.s_ARLEN;
            r_id <= s.s_ARID;
            r_cnt <= '0;
            s.s_ARREADY <= 1'b0;
            r_st <= R_FETCH;
          end
        end
        R_FETCH: begin
          s.s_RDATA <= mem[r_idx];
          s.s_RID <= r_id;
          s.s_RLAST <= r_cnt == r_len;
          s.s_RVALID <= 1'b1;
          r_st <= R_DATA;
        end
        R_DATA:
          if (s.s_RREADY) begin
            s.s_RVALID <= 1'b0;
            if (s.s_RLAST) begin
              s.s_ARREADY <= 1'b1;
              r_st <= R_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
              r_cnt <= r_cnt + 8'd1;
              r_st <= R_FETCH;
            end
          end
        default: r_st <= R_IDLE;
      endcase
endmodule

// File: tb/tb_axi4_mem_responder.sv
// tb_axi4_mem_responder: directed and randomized bursts checked against a word-array memory model
module tb_axi4_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [511:0] ref_mem [1024];
  logic [511:0] wd_q[$];
  logic [63:0] ws_q[$];
  axi4_mem_responder_if #(.ADDR_W(64), .DATA_W(512)) bus ();
  axi4_mem_responder #(.ADDR_W(64), .DATA_W(512), .DEPTH_LOG2(10)) dut (.clk(clk), .reset(reset), .s(bus));
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic sel(input int w);
    case (w)
      0: return bus.s_AWREADY;
      1: return bus.s_WREADY;
      2: return bus.s_BVALID;
      3: return bus.s_ARREADY;
      default: return bus.s_RVALID;
    endcase
  endfunction
  task automatic wait_for(input int w, input string tag);
    int t = 0;
    while (sel(w) !== 1'b1 && t < 64) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tag, sel(w), 1);
  endtask
  function automatic logic [511:0] rnd();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  task automatic wr(input logic [63:0] addr, input int len, input logic [5:0] id, input int last_at, input int bstall);
    int idx;
    bit err;
    logic [511:0] d;
    logic [63:0] st;
    idx = int'(addr[15:6]);
    err = 0;
    chk("wready_idle", bus.s_WREADY, 0);
    bus.s_AWVALID = 1; bus.s_AWADDR = addr; bus.s_AWLEN = len[7:0]; bus.s_AWID = id;
    wait_for(0, "aw_accept");
    @(posedge clk); #1;
    bus.s_AWVALID = 0;
    chk("awready_busy", bus.s_AWREADY, 0);
    for (int k = 0; k <= len; k++) begin
      d = wd_q.pop_front();
      st = ws_q.pop_front();
      bus.s_WVALID = 1; bus.s_WDATA = d; bus.s_WSTRB = st; bus.s_WLAST = (k == last_at);
      wait_for(1, "w_accept");
      @(posedge clk); #1;
      for (int b = 0; b < 64; b++) if (st[b]) ref_mem[(idx + k) % 1024][8*b +: 8] = d[8*b +: 8];
      if ((k == last_at) != (k == len)) err = 1;
    end
    bus.s_WVALID = 0; bus.s_WLAST = 0;
    chk("wready_after_last", bus.s_WREADY, 0);
    wait_for(2, "bvalid");
    for (int c = 0; c < bstall; c++) begin
      @(posedge clk); #1;
      chk("bvalid_held", bus.s_BVALID, 1);
      chk("awready_in_resp", bus.s_AWREADY, 0);
    end
    chk("bid", bus.s_BID, id);
    chk("bresp", bus.s_BRESP, err ? 2'b10 : 2'b00);
    bus.s_BREADY = 1;
    @(posedge clk); #1;
    bus.s_BREADY = 0;
    chk("bvalid_clear", bus.s_BVALID, 0);
    chk("awready_back", bus.s_AWREADY, 1);
  endtask
  task automatic rd(input logic [63:0] addr, input int len, input logic [5:0] id, input int stall_at, input int stall_n);
    int idx;
    logic [511:0] d;
    logic l;
    idx = int'(addr[15:6]);
    bus.s_ARVALID = 1; bus.s_ARADDR = addr; bus.s_ARLEN = len[7:0]; bus.s_ARID = id;
    wait_for(3, "ar_accept");
    @(posedge clk); #1;
    bus.s_ARVALID = 0;
    chk("rvalid_fetch", bus.s_RVALID, 0);
    @(posedge clk); #1;
    chk("rvalid_latency", bus.s_RVALID, 1);
    for (int k = 0; k <= len; k++) begin
      if (k > 0) begin
        chk("rvalid_gap", bus.s_RVALID, 0);
        @(posedge clk); #1;
        chk("rvalid_after_gap", bus.s_RVALID, 1);
      end
      if (k == stall_at) begin
        d = bus.s_RDATA;
        l = bus.s_RLAST;
        repeat (stall_n) begin
          @(posedge clk); #1;
          chk("rvalid_stall", bus.s_RVALID, 1);
          chk("rdata_stable", bus.s_RDATA, d);
          chk("rlast_stable", bus.s_RLAST, l);
        end
      end
      chk("rdata", bus.s_RDATA, ref_mem[(idx + k) % 1024]);
      chk("rid", bus.s_RID, id);
      chk("rlast", bus.s_RLAST, k == len);
      chk("rresp", bus.s_RRESP, 0);
      bus.s_RREADY = 1;
      @(posedge clk); #1;
      bus.s_RREADY = 0;
    end
    chk("rvalid_done", bus.s_RVALID, 0);
    chk("arready_back", bus.s_ARREADY, 1);
  endtask
  task automatic push_full(input int n);
    for (int k = 0; k < n; k++) begin
      wd_q.push_back(rnd());
      ws_q.push_back('1);
    end
  endtask
  initial begin
    logic [63:0] a;
    int len;
    logic [511:0] d;
    bus.s_AWVALID = 0; bus.s_AWADDR = 0; bus.s_AWLEN = 0; bus.s_AWID = 0;
    bus.s_WVALID = 0; bus.s_WDATA = 0; bus.s_WSTRB = 0; bus.s_WLAST = 0; bus.s_BREADY = 0;
    bus.s_ARVALID = 0; bus.s_ARADDR = 0; bus.s_ARLEN = 0; bus.s_ARID = 0; bus.s_RREADY = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", bus.s_AWREADY, 0);
    chk("rst_arready", bus.s_ARREADY, 0);
    chk("rst_wready", bus.s_WREADY, 0);
    chk("rst_bvalid", bus.s_BVALID, 0);
    chk("rst_rvalid", bus.s_RVALID, 0);
    chk("rst_rlast", bus.s_RLAST, 0);
    reset = 0;
    @(posedge clk); #1;
    chk("post_rst_awready", bus.s_AWREADY, 1);
    chk("post_rst_arready", bus.s_ARREADY, 1);
    for (int k = 0; k < 4; k++) begin
      wd_q.push_back(512'(k));
      ws_q.push_back('1);
    end
    wr(64'h40, 3, 6'd5, 3, 0);
    rd(64'h40, 3, 6'd9, -1, 0);
    wd_q.push_back('1); ws_q.push_back('1);
    wr(64'h140, 0, 6'd1, 0, 0);
    d = rnd();
    d[7:0] = 8'hAA;
    wd_q.push_back(d); ws_q.push_back(64'h1);
    wr(64'h140, 0, 6'd2, 0, 0);
    rd(64'h140, 0, 6'd3, -1, 0);
    push_full(2);
    wr(64'd1023 * 64, 1, 6'd7, 1, 4);
    rd(64'd1023 * 64, 1, 6'd8, 0, 5);
    rd(64'h0, 0, 6'd4, -1, 0);
    push_full(4);
    wr(64'd20 * 64, 3, 6'd6, 1, 0);
    rd(64'd20 * 64, 3, 6'd10, 2, 2);
    push_full(1);
    wr(64'd30 * 64, 0, 6'd11, 0, 0);
    push_full(1);
    wr(64'd31 * 64, 0, 6'd12, -1, 1);
    rd(64'd30 * 64, 1, 6'd13, 1, 1);
    for (int it = 0; it < 6; it++) begin
      a = 64'($urandom_range(100, 900)) * 64 + 64'($urandom_range(0, 63));
      len = $urandom_range(0, 7);
      push_full(len + 1);
      wr(a, len, 6'($urandom), len, $urandom_range(0, 2));
      for (int k = 0; k <= len; k++) begin
        wd_q.push_back(rnd());
        ws_q.push_back({$urandom, $urandom});
      end
      wr(a, len, 6'($urandom), len, 0);
      rd(a, len, 6'($urandom), $urandom_range(0, len), $urandom_range(0, 3));
    end
    push_full(5);
    fork
      wr(64'd40 * 64, 4, 6'd20, 4, 1);
      rd(64'd20 * 64, 3, 6'd21, 1, 2);
    join
    rd(64'd40 * 64, 4, 6'd22, -1, 0);
    bus.s_ARVALID = 1; bus.s_ARADDR = 64'h40; bus.s_ARLEN = 8'd7; bus.s_ARID = 6'd3;
    wait_for(3, "ar_accept_mid");
    @(posedge clk); #1;
    bus.s_ARVALID = 0;
    @(posedge clk); #1;
    chk("mid_rvalid", bus.s_RVALID, 1);
    reset = 1;
    @(posedge clk); #1;
    chk("mid_rst_rvalid", bus.s_RVALID, 0);
    chk("mid_rst_arready", bus.s_ARREADY, 0);
    reset = 0;
    @(posedge clk); #1;
    chk("mid_post_arready", bus.s_ARREADY, 1);
    chk("mid_post_rvalid", bus.s_RVALID, 0);
    rd(64'h40, 3, 6'd9, -1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
